// File: rtl/gat_bram_loader.sv
// gat_bram_loader: segments a header/payload word stream into byte-addressed writes to four accelerator BRAMs
module gat_bram_loader #(
  parameter int TOP_WIDTH          = 32,
  parameter int ADDR_W             = 20,
  parameter int H_DATA_DEPTH       = 242101,
  parameter int NODE_INFO_DEPTH    = 13264,
  parameter int WEIGHT_DEPTH       = 22928,
  parameter int SUBGRAPH_IDX_DEPTH = 13264
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic                 clr_done,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [ADDR_W-1:0]    bram_addra,
  output logic [3:0]           bram_ena,
  output logic [3:0]           bram_wea,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  output logic                 subgraph_bram_load_done,
  output logic                 load_err,
  output logic                 busy
);
  typedef enum logic [1:0] {HDR, LOAD, DONE} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             region_q, region_d;
  logic [29:0]            count_q, count_d, idx_q, idx_d;
  logic                   seg_err_q, seg_err_d;
  logic [TOP_WIDTH-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [3:0]             ena_q, ena_d, done_q, done_d;
  logic                   err_q, err_d;
  logic                   fire, last_beat;
  logic [29:0]            hdr_depth, cur_depth;

  function automatic logic [29:0] depth_of(input logic [1:0] r);
    return r == 2'd0 ? 30'(H_DATA_DEPTH) :
           r == 2'd1 ? 30'(NODE_INFO_DEPTH) :
           r == 2'd2 ? 30'(WEIGHT_DEPTH) : 30'(SUBGRAPH_IDX_DEPTH);
  endfunction

  assign s_ready    = state_q != DONE;
  assign busy       = state_q == LOAD;
  assign fire       = s_valid && s_ready;
  assign last_beat  = idx_q == count_q - 30'd1;
  assign hdr_depth  = depth_of(s_data[31:30]);
  assign cur_depth  = depth_of(region_q);
  assign bram_din   = din_q;
  assign bram_addra = addr_q;
  assign bram_ena   = ena_q;
  assign bram_wea   = ena_q;
  assign {subgraph_bram_load_done, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done} = done_q;
  assign load_err   = err_q;

  // Header decode, payload write generation and per-segment completion; flag sets override clr_done
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    count_d   = count_q;
    idx_d     = idx_q;
    seg_err_d = seg_err_q;
    din_d     = din_q;
    addr_d    = addr_q;
    ena_d     = '0;
    done_d    = clr_done ? 4'b0 : done_q;
    err_d     = clr_done ? 1'b0 : err_q;
    case (state_q)
      HDR: if (fire) begin
        region_d  = s_data[31:30];
        count_d   = s_data[29:0];
        idx_d     = '0;
        seg_err_d = s_data[29:0] > hdr_depth;
        err_d     = err_d | seg_err_d;
        state_d   = s_data[29:0] == 30'd0 ? DONE : LOAD;
      end
      LOAD: if (fire) begin
        din_d   = s_data;
        addr_d  = {idx_q[ADDR_W-3:0], 2'b00};
        ena_d   = idx_q < cur_depth ? 4'b0001 << region_q : 4'b0000;
        idx_d   = idx_q + 30'd1;
        if (last_beat || s_last) begin
          state_d = DONE;
          if (last_beat != s_last) begin
            seg_err_d = 1'b1;
            err_d     = 1'b1;
          end
        end
      end
      DONE: begin
        if (!seg_err_q) done_d[region_q] = 1'b1;
        state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HDR;
      region_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      seg_err_q <= 1'b0;
      din_q     <= '0;
      addr_q    <= '0;
      ena_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      seg_err_q <= seg_err_d;
      din_q     <= din_d;
      addr_q    <= addr_d;
      ena_q     <= ena_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_gat_bram_loader.sv
// tb_gat_bram_loader: table-driven and directed sequence checks of the segment loader
module tb_gat_bram_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, clr_done = 1'b0;
  logic        s_ready, load_err, busy;
  logic [31:0] bram_din;
  logic [19:0] bram_addra;
  logic [3:0]  bram_ena, bram_wea, done;
  logic        d0, d1, d2, d3;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        v, l, c, rdy;
    logic [3:0]  ena;
    logic [19:0] addr;
    logic [31:0] din;
    logic [3:0]  done;
    logic        err;
  } vec_t;
  typedef struct {
    logic [3:0]  ena;
    logic [19:0] addr;
    logic [31:0] din;
  } wr_t;
  vec_t tbl[15];
  wr_t  wq[$];

  assign done = {d3, d2, d1, d0};

  gat_bram_loader dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .clr_done(clr_done), .bram_din(bram_din), .bram_addra(bram_addra),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .h_data_bram_load_done(d0),
    .h_node_info_bram_load_done(d1), .wgt_bram_load_done(d2), .subgraph_bram_load_done(d3),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic v, input logic l, input logic c);
    @(negedge clk);
    s_data = d; s_valid = v; s_last = l; clr_done = c;
    @(posedge clk);
    #1;
    if (bram_ena != 4'b0) wq.push_back('{bram_ena, bram_addra, bram_din});
    if (bram_wea !== bram_ena) begin
      checks++; errors++;
      $display("FAIL wea: got %0h expected %0h", bram_wea, bram_ena);
    end
  endtask

  task automatic idle(input logic c = 1'b0);
    cyc(32'h0, 1'b0, 1'b0, c);
  endtask

  initial begin
    tbl[0]  = '{32'h80000003, 1, 0, 0, 1, 4'h0, 20'd0, 32'h0,        4'h0, 0};
    tbl[1]  = '{32'hAAAA0001, 1, 0, 0, 1, 4'h4, 20'd0, 32'hAAAA0001, 4'h0, 0};
    tbl[2]  = '{32'hBBBB0002, 1, 0, 0, 1, 4'h4, 20'd4, 32'hBBBB0002, 4'h0, 0};
    tbl[3]  = '{32'hCCCC0003, 1, 1, 0, 0, 4'h4, 20'd8, 32'hCCCC0003, 4'h0, 0};
    tbl[4]  = '{32'h0,        0, 0, 0, 1, 4'h0, 20'd8, 32'hCCCC0003, 4'h4, 0};
    tbl[5]  = '{32'h00000000, 1, 0, 0, 0, 4'h0, 20'd8, 32'hCCCC0003, 4'h4, 0};
    tbl[6]  = '{32'h0,        0, 0, 0, 1, 4'h0, 20'd8, 32'hCCCC0003, 4'h5, 0};
    tbl[7]  = '{32'h40000001, 1, 0, 0, 1, 4'h0, 20'd8, 32'hCCCC0003, 4'h5, 0};
    tbl[8]  = '{32'h12345678, 1, 1, 0, 0, 4'h2, 20'd0, 32'h12345678, 4'h5, 0};
    tbl[9]  = '{32'h0,        0, 0, 1, 1, 4'h0, 20'd0, 32'h12345678, 4'h2, 0};
    tbl[10] = '{32'hC0000002, 1, 0, 0, 1, 4'h0, 20'd0, 32'h12345678, 4'h2, 0};
    tbl[11] = '{32'h11110001, 1, 0, 0, 1, 4'h8, 20'd0, 32'h11110001, 4'h2, 0};
    tbl[12] = '{32'h22220002, 1, 0, 0, 0, 4'h8, 20'd4, 32'h22220002, 4'h2, 1};
    tbl[13] = '{32'h0,        0, 0, 0, 1, 4'h0, 20'd4, 32'h22220002, 4'h2, 1};
    tbl[14] = '{32'h0,        0, 0, 1, 1, 4'h0, 20'd4, 32'h22220002, 4'h0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", s_ready, 1);
    chk("reset_ena", bram_ena, 0);
    chk("reset_done", done, 0);
    chk("reset_err", load_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_addr_din", {bram_addra, bram_din}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].data, tbl[i].v, tbl[i].l, tbl[i].c);
      chk($sformatf("v%0d_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("v%0d_ena", i), bram_ena, tbl[i].ena);
      chk($sformatf("v%0d_addr", i), bram_addra, tbl[i].addr);
      chk($sformatf("v%0d_din", i), bram_din, tbl[i].din);
      chk($sformatf("v%0d_done", i), done, tbl[i].done);
      chk($sformatf("v%0d_err", i), load_err, tbl[i].err);
    end

    wq.delete();
    cyc(32'h40000008, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(32'd100 + 32'(i / 2), i % 2 == 0, i == 14, 0);
    idle();
    chk("tog_writes", wq.size(), 8);
    for (int i = 0; i < wq.size() && i < 8; i++)
      chk($sformatf("tog_w%0d", i), {wq[i].ena, wq[i].addr, wq[i].din}, {4'h2, 20'(i * 4), 32'd100 + 32'(i)});
    chk("tog_done", done, 4'h2);
    chk("tog_err", load_err, 0);
    idle(1);

    wq.delete();
    cyc({2'd3, 30'd13265}, 1, 0, 0);
    chk("ovf_err_at_hdr", load_err, 1);
    chk("ovf_busy", busy, 1);
    for (int i = 0; i < 13265; i++) cyc(32'(i), 1, i == 13264, 0);
    chk("ovf_last_beat_taken", s_ready, 0);
    idle();
    chk("ovf_writes", wq.size(), 13264);
    if (wq.size() > 0) chk("ovf_last_write", {wq[$].ena, wq[$].addr, wq[$].din}, {4'h8, 20'd53052, 32'd13263});
    chk("ovf_done", done, 0);
    chk("ovf_err", load_err, 1);
    idle(1);

    wq.delete();
    cyc({2'd0, 30'd5}, 1, 0, 0);
    cyc(32'hE1, 1, 0, 0);
    cyc(32'hE2, 1, 1, 0);
    chk("early_err", load_err, 1);
    chk("early_ready", s_ready, 0);
    idle();
    chk("early_writes", wq.size(), 2);
    chk("early_hdr", {busy, s_ready}, 2'b01);
    chk("early_done", done, 0);
    cyc({2'd2, 30'd2}, 1, 0, 0);
    cyc(32'hF1, 1, 0, 0);
    cyc(32'hF2, 1, 1, 0);
    idle();
    chk("next_writes", wq.size(), 4);
    if (wq.size() == 4) chk("next_w1", {wq[3].ena, wq[3].addr, wq[3].din}, {4'h4, 20'd4, 32'hF2});
    chk("next_done", done, 4'h4);
    idle(1);

    wq.delete();
    cyc({2'd2, 30'd1}, 1, 1'b0, 0);
    cyc(32'h55, 1, 1, 0);
    idle();
    cyc({2'd1, 30'd4}, 1, 0, 0);
    cyc(32'h71, 1, 0, 0);
    cyc(32'h72, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ena", bram_ena, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    cyc({2'd0, 30'd1}, 1, 0, 0);
    chk("post_rst_busy", busy, 1);
    cyc(32'h99, 1, 1, 0);
    idle();
    chk("post_rst_writes", wq.size(), 1);
    if (wq.size() == 1) chk("post_rst_w0", {wq[0].ena, wq[0].addr, wq[0].din}, {4'h1, 20'd0, 32'h99});
    chk("post_rst_done", done, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
